// File: rtl/wbslvmem_if.sv
// Wishbone B4 pipelined bus bundle between a master and the wbslvmem responder.
interface wbslvmem_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          i_wb_cyc;
    logic          i_wb_stb;
    logic          i_wb_we;
    logic [AW-1:0] i_wb_addr;
    logic [DW-1:0] i_wb_data;
    logic          o_wb_ack;
    logic          o_wb_stall;
    logic [DW-1:0] o_wb_data;
    logic          o_wb_err;

    modport master (
        output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
        input  o_wb_ack, o_wb_stall, o_wb_data, o_wb_err
    );

    modport slave (
        input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
        output o_wb_ack, o_wb_stall, o_wb_data, o_wb_err
    );
endinterface

// File: rtl/wbslvmem.sv
// Pipelined Wishbone B4 slave memory with an in-order request queue.
// Optional feature macro: WBSLVMEM_ERR_EN (out-of-range addresses return err).
module wbslvmem #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned LGMEMSZ = 10,
    parameter int unsigned LGFIFO  = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    wbslvmem_if.slave       wb,
    input  logic            i_hold,
    output logic [LGFIFO:0] o_nqueued
);
    localparam int unsigned DEPTH = 2 ** LGFIFO;
    localparam int unsigned CW    = LGFIFO + 1;
    localparam int unsigned MEMSZ = 2 ** LGMEMSZ;

    typedef struct packed {
        logic               we;
        logic               oor;
        logic [LGMEMSZ-1:0] idx;
        logic [DW-1:0]      data;
    } req_t;

    req_t              fifo_q [DEPTH];
    logic [DW-1:0]     mem    [MEMSZ];

    logic [LGFIFO-1:0] wr_ptr_q, wr_ptr_d;
    logic [LGFIFO-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q,  count_d;
    logic              ack_q,    ack_d;
    logic              err_q,    err_d;
    logic [DW-1:0]     rdata_q,  rdata_d;

    logic              stall_c;
    logic              push_c;
    logic              pop_c;
    logic              req_oor_c;
    req_t              push_req_c;
    req_t              head_c;

`ifdef WBSLVMEM_ERR_EN
    assign req_oor_c = (wb.i_wb_addr >> LGMEMSZ) != '0;
`else
    assign req_oor_c = 1'b0;
`endif

    assign stall_c    = (count_q == CW'(DEPTH));
    assign push_c     = wb.i_wb_cyc && wb.i_wb_stb && !stall_c;
    assign pop_c      = (count_q != '0) && !i_hold && wb.i_wb_cyc;
    assign head_c     = fifo_q[rd_ptr_q];
    assign push_req_c = '{we:   wb.i_wb_we,
                          oor:  req_oor_c,
                          idx:  wb.i_wb_addr[LGMEMSZ-1:0],
                          data: wb.i_wb_data};

    assign wb.o_wb_stall = stall_c;
    assign wb.o_wb_ack   = ack_q;
    assign wb.o_wb_err   = err_q;
    assign wb.o_wb_data  = rdata_q;
    assign o_nqueued     = count_q;

    // Queue storage: capture accepted requests at the tail.
    always_ff @(posedge i_clk) begin
        if (push_c) fifo_q[wr_ptr_q] <= push_req_c;
    end

    // RAM write port: only the popped head writes, never a flushed entry.
    always_ff @(posedge i_clk) begin
        if (pop_c && head_c.we && !head_c.oor) mem[head_c.idx] <= head_c.data;
    end

    // Next-state: pointers, occupancy, and the registered response.
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        rdata_d  = rdata_q;
        if (!wb.i_wb_cyc) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_c) wr_ptr_d = wr_ptr_q + LGFIFO'(1);
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + LGFIFO'(1);
                err_d    = head_c.oor;
                ack_d    = !head_c.oor;
                if (!head_c.we && !head_c.oor) rdata_d = mem[head_c.idx];
            end
            if (push_c && !pop_c)      count_d = count_q + CW'(1);
            else if (!push_c && pop_c) count_d = count_q - CW'(1);
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end
endmodule
